// File: rtl/mbe_sched_pkg.sv
// Shared widths, pipeline tag and arbiter state encoding for the MBE multiplier scheduler.
package mbe_sched_pkg;
  localparam int OP_W = 24;
  localparam int P_W  = 48;
  localparam int NREQ = 2;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_state_e;
endpackage

// File: rtl/mbe_mult_scheduler_if.sv
// Signal bundle between the requesters, the scheduler and the shared multiplier.
interface mbe_mult_scheduler_if;
  logic [mbe_sched_pkg::NREQ-1:0]                          req_valid;
  logic [mbe_sched_pkg::NREQ-1:0]                          req_ready;
  logic [mbe_sched_pkg::NREQ-1:0][mbe_sched_pkg::OP_W-1:0] req_a;
  logic [mbe_sched_pkg::NREQ-1:0][mbe_sched_pkg::OP_W-1:0] req_b;
  logic                                                    mul_valid;
  logic [mbe_sched_pkg::OP_W-1:0]                          mul_a;
  logic [mbe_sched_pkg::OP_W-1:0]                          mul_b;
  logic [mbe_sched_pkg::P_W-1:0]                           mul_p;
  logic [mbe_sched_pkg::NREQ-1:0]                          rsp_valid;
  logic [mbe_sched_pkg::NREQ-1:0]                          rsp_ready;
  logic [mbe_sched_pkg::NREQ-1:0][mbe_sched_pkg::P_W-1:0]  rsp_p;
  logic                                                    busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_p, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_p, busy
  );
endinterface

// File: rtl/mbe_rsp_fifo.sv
// Per-requester result buffer; head reads as zero while empty.
module mbe_rsp_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/mbe_mult_scheduler.sv
// Arbitrates two requesters onto one pipelined MBE multiplier with credit-limited result buffers.
// Define MBE_SCHED_STATS_EN to add the issue_cnt/stall_cnt statistics outputs.
// state | meaning
// PRI0  | requester 0 wins when both are eligible
// PRI1  | requester 1 wins when both are eligible
module mbe_mult_scheduler
  import mbe_sched_pkg::*;
#(
  parameter int MULT_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mbe_mult_scheduler_if.slave   bus
`ifdef MBE_SCHED_STATS_EN
  ,
  output logic [NREQ-1:0][31:0] issue_cnt,
  output logic [NREQ-1:0][31:0] stall_cnt
`endif
);
  localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

  pri_state_e                 state_q, state_d;
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]            elig, grant, rsp_hs, fifo_empty, wr_sel;
  logic                       gid;
  logic                       mul_valid_q, mul_id_q;
  logic [OP_W-1:0]            mul_a_q, mul_b_q;
  tag_t                       tag_q [MULT_LAT];
  logic                       wr_vld_q, wr_id_q;
  logic [P_W-1:0]             wr_p_q;
  logic [NREQ-1:0][P_W-1:0]   rsp_p_w;

  // Credits cover in-flight plus buffered results, so a FIFO can never overflow.
  always_comb begin
    for (int i = 0; i < NREQ; i++) elig[i] = bus.req_valid[i] && (cnt_q[i] < CNT_MAX);
  end

  always_comb begin
    state_d = state_q;
    grant   = '0;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (state_q == PRI0) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
    if (grant[0])      state_d = PRI1;
    else if (grant[1]) state_d = PRI0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRI0;
    else        state_q <= state_d;
  end

  assign gid = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_valid_q <= 1'b0;
      mul_id_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      mul_valid_q <= |grant;
      if (|grant) begin
        mul_id_q <= gid;
        mul_a_q  <= bus.req_a[gid];
        mul_b_q  <= bus.req_b[gid];
      end
    end
  end

  // Tag stage 0 is loaded from the issue strobe, so the last stage lines up with mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MULT_LAT; k++) tag_q[k] <= '0;
      wr_vld_q <= 1'b0;
      wr_id_q  <= 1'b0;
      wr_p_q   <= '0;
    end else begin
      tag_q[0] <= tag_t'{valid: mul_valid_q, id: mul_id_q};
      for (int k = 1; k < MULT_LAT; k++) tag_q[k] <= tag_q[k-1];
      wr_vld_q <= tag_q[MULT_LAT-1].valid;
      if (tag_q[MULT_LAT-1].valid) begin
        wr_id_q <= tag_q[MULT_LAT-1].id;
        wr_p_q  <= bus.mul_p;
      end
    end
  end

  assign wr_sel = {wr_vld_q & wr_id_q, wr_vld_q & ~wr_id_q};
  assign rsp_hs = ~fifo_empty & bus.rsp_ready;

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    mbe_rsp_fifo #(
      .W     (P_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_sel[i]),
      .wr_data_i (wr_p_q),
      .rd_en_i   (rsp_hs[i]),
      .rd_data_o (rsp_p_w[i]),
      .empty_o   (fifo_empty[i])
    );
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !rsp_hs[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!grant[i] && rsp_hs[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.req_ready = grant;
  assign bus.mul_valid = mul_valid_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_p     = rsp_p_w;
  assign bus.busy      = (cnt_q[0] != '0) || (cnt_q[1] != '0);

`ifdef MBE_SCHED_STATS_EN
  logic [NREQ-1:0][31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i])                         issue_cnt_q[i] <= issue_cnt_q[i] + 32'd1;
        if (bus.req_valid[i] && !grant[i])    stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
      end
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mbe_mult_scheduler.sv
// Scoreboard bench for mbe_mult_scheduler with a behavioural MULT_LAT-stage multiplier.
`timescale 1ns/1ps
module tb_mbe_mult_scheduler;
  import mbe_sched_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
    bit          chk;
  } op_t;

  typedef struct {
    logic [47:0] p;
    int          due;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbe_mult_scheduler_if bus ();

`ifdef MBE_SCHED_STATS_EN
  logic [1:0][31:0] issue_cnt, stall_cnt;
`endif

  mbe_mult_scheduler #(
    .MULT_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MBE_SCHED_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Behavioural multiplier: product appears LAT cycles after the issue cycle.
  logic [47:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= 48'(bus.mul_a) * 48'(bus.mul_b);
    for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign bus.mul_p = pipe_q[LAT-1];

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  op_t  src0[$], src1[$];
  exp_t exp0[$], exp1[$];
  int   checks = 0;
  int   errors = 0;
  int   iss[2];
  int   rsp_seen = 0;
  bit   chk_order = 0;
  int   next_port = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic add(input int port, input logic [23:0] a, input logic [23:0] b,
                     input logic [47:0] p, input bit c = 1'b0);
    op_t o;
    o.a = a; o.b = b; o.p = p; o.chk = c;
    if (port == 0) src0.push_back(o);
    else           src1.push_back(o);
  endtask

  // Drive one cycle of requests; a handshake seen here completes at the next rising edge.
  task automatic step(input logic [1:0] vmask);
    op_t  o0, o1;
    exp_t e;
    @(negedge clk);
    bus.req_valid = '0;
    if (vmask[0] && src0.size() > 0) begin
      o0 = src0[0];
      bus.req_valid[0] = 1'b1; bus.req_a[0] = o0.a; bus.req_b[0] = o0.b;
    end
    if (vmask[1] && src1.size() > 0) begin
      o1 = src1[0];
      bus.req_valid[1] = 1'b1; bus.req_a[1] = o1.a; bus.req_b[1] = o1.b;
    end
    #1;
    chk("one_grant", 64'(bus.req_ready == 2'b11), 64'd0);
    if (bus.req_valid[0] && bus.req_ready[0]) begin
      e.p = o0.p; e.chk = o0.chk; e.due = cyc + 1 + LAT + 2;
      exp0.push_back(e); void'(src0.pop_front()); iss[0]++;
      if (chk_order) begin chk("grant_order", 64'd0, 64'(next_port)); next_port = 1; end
    end
    if (bus.req_valid[1] && bus.req_ready[1]) begin
      e.p = o1.p; e.chk = o1.chk; e.due = cyc + 1 + LAT + 2;
      exp1.push_back(e); void'(src1.pop_front()); iss[1]++;
      if (chk_order) begin chk("grant_order", 64'd1, 64'(next_port)); next_port = 0; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 && n < 300) begin
      step(2'b11);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", src0.size() + src1.size() + exp0.size() + exp1.size());
    end
    step(2'b00);
    step(2'b00);
    chk("busy_idle", 64'(bus.busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (rst_n) begin
      if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
        rsp_seen++;
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp0: got 0x%0h expected no response", bus.rsp_p[0]);
        end else begin
          e = exp0.pop_front();
          chk("rsp_p0", 64'(bus.rsp_p[0]), 64'(e.p));
          if (e.chk) chk("latency0", 64'(cyc), 64'(e.due));
        end
      end
      if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
        rsp_seen++;
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp1: got 0x%0h expected no response", bus.rsp_p[1]);
        end else begin
          e = exp1.pop_front();
          chk("rsp_p1", 64'(bus.rsp_p[1]), 64'(e.p));
          if (e.chk) chk("latency1", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 2'b11;
    iss[0] = 0; iss[1] = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_mul_valid", 64'(bus.mul_valid), 64'd0);
    chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst_mul_b", 64'(bus.mul_b), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_p0", 64'(bus.rsp_p[0]), 64'd0);
    chk("rst_rsp_p1", 64'(bus.rsp_p[1]), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request 3x5, latency checked by the monitor.
    add(0, 24'd3, 24'd5, 48'd15, 1'b1);
    step(2'b01);
    step(2'b00);
    chk("issue_strobe", 64'(bus.mul_valid), 64'd1);
    chk("issue_a", 64'(bus.mul_a), 64'd3);
    chk("issue_b", 64'(bus.mul_b), 64'd5);
    chk("busy_active", 64'(bus.busy), 64'd1);
    step(2'b00);
    chk("strobe_one_cycle", 64'(bus.mul_valid), 64'd0);
    chk("operand_hold", 64'(bus.mul_a), 64'd3);
    drain();

    // Operand extremes.
    add(0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    add(1, 24'h000000, 24'hABCDEF, 48'h0);
    add(1, 24'hFFFFFF, 24'h000001, 48'hFFFFFF);
    drain();

    // Both requesters streaming from reset: strict alternation starting at port 0.
    do_reset();
    chk_order = 1'b1; next_port = 0;
    add(0, 24'd2, 24'd3, 48'd6);          add(1, 24'd100, 24'd100, 48'd10000);
    add(0, 24'd4, 24'd5, 48'd20);         add(1, 24'd1000, 24'd1000, 48'd1000000);
    add(0, 24'd6, 24'd7, 48'd42);         add(1, 24'h1000, 24'h1000, 48'h1000000);
    add(0, 24'd8, 24'd9, 48'd72);         add(1, 24'd3, 24'd3, 48'd9);
    add(0, 24'd10, 24'd11, 48'd110);      add(1, 24'd255, 24'd255, 48'd65025);
    add(0, 24'd12, 24'd13, 48'd156);      add(1, 24'd1, 24'hFFFFFF, 48'hFFFFFF);
    drain();
    chk_order = 1'b0;

    // Port 0 back-pressured: only DEPTH issues, port 1 keeps flowing.
    bus.rsp_ready = 2'b10;
    iss[0] = 0; iss[1] = 0;
    add(0, 24'd2, 24'd3, 48'd6);          add(1, 24'd100, 24'd100, 48'd10000);
    add(0, 24'd4, 24'd5, 48'd20);         add(1, 24'd1000, 24'd1000, 48'd1000000);
    add(0, 24'd6, 24'd7, 48'd42);         add(1, 24'h1000, 24'h1000, 48'h1000000);
    add(0, 24'd8, 24'd9, 48'd72);         add(1, 24'd3, 24'd3, 48'd9);
    add(0, 24'd10, 24'd11, 48'd110);      add(1, 24'd255, 24'd255, 48'd65025);
    add(0, 24'd12, 24'd13, 48'd156);      add(1, 24'd1, 24'hFFFFFF, 48'hFFFFFF);
    add(0, 24'd14, 24'd15, 48'd210);
    add(0, 24'd16, 24'd17, 48'd272);
    repeat (20) step(2'b11);
    chk("port0_issues_capped", 64'(iss[0]), 64'd4);
    chk("port0_ready_blocked", 64'(bus.req_ready[0]), 64'd0);
    chk("port1_issues", 64'(iss[1]), 64'd6);
    chk("port0_rsp_pending", 64'(bus.rsp_valid[0]), 64'd1);
    bus.rsp_ready = 2'b11;
    drain();

    // Reset with two operations in flight.
    add(0, 24'd9, 24'd9, 48'd81);
    add(1, 24'd11, 24'd11, 48'd121);
    step(2'b11);
    step(2'b11);
    step(2'b00);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_mul_valid", 64'(bus.mul_valid), 64'd0);
    chk("midrst_mul_a", 64'(bus.mul_a), 64'd0);
    chk("midrst_mul_b", 64'(bus.mul_b), 64'd0);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = rsp_seen;
    repeat (12) step(2'b00);
    chk("no_rsp_after_reset", 64'(rsp_seen), 64'(snap));
    add(0, 24'd7, 24'd6, 48'd42, 1'b1);
    drain();

    // Statistics scenario: 3 contended cycles, 10 issues on port 1.
    do_reset();
    iss[0] = 0; iss[1] = 0;
    add(0, 24'd2, 24'd3, 48'd6);
    add(0, 24'd4, 24'd5, 48'd20);
    add(0, 24'd6, 24'd7, 48'd42);
    add(1, 24'd100, 24'd100, 48'd10000);
    add(1, 24'd1000, 24'd1000, 48'd1000000);
    add(1, 24'h1000, 24'h1000, 48'h1000000);
    add(1, 24'd3, 24'd3, 48'd9);
    add(1, 24'd255, 24'd255, 48'd65025);
    add(1, 24'd1, 24'hFFFFFF, 48'hFFFFFF);
    add(1, 24'd14, 24'd15, 48'd210);
    add(1, 24'd16, 24'd17, 48'd272);
    add(1, 24'd20, 24'd30, 48'd600);
    add(1, 24'd50, 24'd40, 48'd2000);
    for (int r = 0; r < 3; r++) begin
      step(2'b11);
      step(2'b10);
      step(2'b00);
    end
    for (int r = 0; r < 7; r++) begin
      step(2'b10);
      step(2'b00);
    end
    chk("stats_port0_issues", 64'(iss[0]), 64'd3);
    chk("stats_port1_issues", 64'(iss[1]), 64'd10);
`ifdef MBE_SCHED_STATS_EN
    chk("issue_cnt1", 64'(issue_cnt[1]), 64'd10);
    chk("stall_cnt1", 64'(stall_cnt[1]), 64'd3);
    chk("issue_cnt0", 64'(issue_cnt[0]), 64'd3);
    chk("stall_cnt0", 64'(stall_cnt[0]), 64'd0);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
